// File: rtl/mem_arb_if.sv
// Bundles the IFU, LSU and memory-bus channels of the two-to-one memory arbiter.
// The slave modport is the arbiter's view; master is the requester/bus environment.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic                  i_ifu_req_valid;
    logic                  o_ifu_req_ready;
    logic [ADDR_W-1:0]     i_ifu_addr;
    logic                  o_ifu_rsp_valid;
    logic                  i_ifu_rsp_ready;
    logic [DATA_W-1:0]     o_ifu_rdata;

    logic                  i_lsu_req_valid;
    logic                  o_lsu_req_ready;
    logic [ADDR_W-1:0]     i_lsu_addr;
    logic                  i_lsu_wen;
    logic [DATA_W-1:0]     i_lsu_wdata;
    logic [DATA_W/8-1:0]   i_lsu_wmask;
    logic                  o_lsu_rsp_valid;
    logic                  i_lsu_rsp_ready;
    logic [DATA_W-1:0]     o_lsu_rdata;

    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic                  o_mem_wen;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_wmask;
    logic                  i_mem_rvalid;
    logic                  o_mem_rready;
    logic [DATA_W-1:0]     i_mem_rdata;

    modport slave (
        input  i_ifu_req_valid, i_ifu_addr, i_ifu_rsp_ready,
        input  i_lsu_req_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask, i_lsu_rsp_ready,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rdata,
        output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata,
        output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_rready
    );

    modport master (
        output i_ifu_req_valid, i_ifu_addr, i_ifu_rsp_ready,
        output i_lsu_req_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask, i_lsu_rsp_ready,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rdata,
        input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata,
        input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_rready
    );
endinterface

// File: rtl/mem_arb.sv
// Two-to-one memory-port arbiter: IFU and LSU share one bus, one transaction in flight.
// LSU has priority; a streak counter forces an IFU grant after MAX_STREAK LSU wins.
module mem_arb #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    mem_arb_if.slave bus_io
);
    localparam int unsigned MaskW   = DATA_W / 8;
    localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;  // 1 = LSU owns the bus
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MaskW-1:0]    wmask_q, wmask_d;

    logic grant_ifu, grant_lsu, own_rsp_ready;

    assign own_rsp_ready = owner_q ? bus_io.i_lsu_rsp_ready : bus_io.i_ifu_rsp_ready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_ifu = bus_io.i_ifu_req_valid &&
                            (!bus_io.i_lsu_req_valid || streak_q == StreakMax);
                grant_lsu = bus_io.i_lsu_req_valid && !grant_ifu;
                if (grant_ifu) begin
                    addr_d   = bus_io.i_ifu_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    owner_d  = 1'b0;
                    streak_d = '0;
                    state_d  = StReq;
                end else if (grant_lsu) begin
                    addr_d  = bus_io.i_lsu_addr;
                    wen_d   = bus_io.i_lsu_wen;
                    wdata_d = bus_io.i_lsu_wdata;
                    wmask_d = bus_io.i_lsu_wmask;
                    owner_d = 1'b1;
                    state_d = StReq;
                    // Only a waiting IFU makes an LSU win count toward the streak.
                    if (!bus_io.i_ifu_req_valid) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus_io.i_mem_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (bus_io.i_mem_rvalid && own_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            streak_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    // Grants are combinational on the request valids, so mask them while reset is held.
    assign bus_io.o_ifu_req_ready = grant_ifu && !i_rst;
    assign bus_io.o_lsu_req_ready = grant_lsu && !i_rst;

    assign bus_io.o_mem_valid = (state_q == StReq);
    assign bus_io.o_mem_addr  = addr_q;
    assign bus_io.o_mem_wen   = wen_q;
    assign bus_io.o_mem_wdata = wdata_q;
    assign bus_io.o_mem_wmask = wmask_q;

    assign bus_io.o_mem_rready    = (state_q == StRsp) && own_rsp_ready;
    assign bus_io.o_ifu_rsp_valid = (state_q == StRsp) && !owner_q && bus_io.i_mem_rvalid;
    assign bus_io.o_lsu_rsp_valid = (state_q == StRsp) && owner_q && bus_io.i_mem_rvalid;
    assign bus_io.o_ifu_rdata     = bus_io.i_mem_rdata;
    assign bus_io.o_lsu_rdata     = bus_io.i_mem_rdata;
endmodule
